// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: static, bimodal or gshare lookup
// over a table of saturating counters, trained non-speculatively from EX.
module branch_predictor #(
  parameter int XLEN      = 64,
  parameter int IDX_BITS  = 4,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 4,
  parameter int MODE      = 1,
  parameter int STAT_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      lookup_pc,
  input  logic [31:0]          lookup_instruction,
  output logic                 predict_is_branch,
  output logic                 predict_taken,
  output logic [XLEN-1:0]      predict_target,
  output logic [IDX_BITS-1:0]  predict_index,
  input  logic                 update_valid,
  input  logic [IDX_BITS-1:0]  update_index,
  input  logic                 update_taken,
  input  logic                 update_mispredict,
  output logic [HIST_BITS-1:0] ghr_out,
  output logic [STAT_W-1:0]    stat_branches,
  output logic [STAT_W-1:0]    stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [STAT_W-1:0]    statBranches_q, statBranches_d;
  logic [STAT_W-1:0]    statMispredicts_q, statMispredicts_d;

  logic [IDX_BITS-1:0]  pcIdx;
  logic [IDX_BITS-1:0]  lookupIdx;
  logic [12:0]          bImm;
  logic [XLEN-1:0]      bImmExt;
  logic                 isBranch;
  logic                 takenPred;
  logic                 unusedBits;

  // The decoder only needs the opcode and the B-type immediate fields.
  assign unusedBits = ^lookup_instruction[24:12];

  always_comb begin
    pcIdx     = lookup_pc[IDX_BITS+1:2];
    lookupIdx = pcIdx;
    if (MODE == 2) begin
      lookupIdx = pcIdx ^ IDX_BITS'(ghr_q);
    end
    isBranch  = (lookup_instruction[6:0] == 7'b1100011);
    bImm      = {lookup_instruction[31], lookup_instruction[7],
                 lookup_instruction[30:25], lookup_instruction[11:8], 1'b0};
    bImmExt   = {{(XLEN-13){bImm[12]}}, bImm};
    takenPred = 1'b0;
    if (isBranch) begin
      takenPred = (MODE == 0) ? 1'b1 : ctr_q[lookupIdx][CTR_BITS-1];
    end
  end

  assign predict_is_branch = isBranch;
  assign predict_taken     = takenPred;
  assign predict_index     = lookupIdx;
  assign predict_target    = lookup_pc + (takenPred ? bImmExt : XLEN'(4));
  assign ghr_out           = ghr_q;
  assign stat_branches     = statBranches_q;
  assign stat_mispredicts  = statMispredicts_q;

  // Training values for the resolved branch; all counters saturate rather than wrap.
  always_comb begin
    ctr_d = ctr_q[update_index];
    if (update_taken) begin
      if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_BITS'(1);
    end else begin
      if (ctr_d != '0) ctr_d = ctr_d - CTR_BITS'(1);
    end
    ghr_d = HIST_BITS'({ghr_q, update_taken});
    statBranches_d = statBranches_q;
    if (statBranches_q != '1) statBranches_d = statBranches_q + STAT_W'(1);
    statMispredicts_d = statMispredicts_q;
    if (update_mispredict && (statMispredicts_q != '1)) begin
      statMispredicts_d = statMispredicts_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WEAK;
      ghr_q             <= '0;
      statBranches_q    <= '0;
      statMispredicts_q <= '0;
    end else if (update_valid) begin
      if (MODE != 0) ctr_q[update_index] <= ctr_d;
      ghr_q             <= ghr_d;
      statBranches_q    <= statBranches_d;
      statMispredicts_q <= statMispredicts_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: static, bimodal and gshare instances
// share the lookup port and are checked against hand-computed values.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        upValid, up2Valid;
  logic [3:0]  upIdx;
  logic        upTaken, upMisp;

  logic        isBr0, tk0, isBr1, tk1, isBr2, tk2;
  logic [63:0] tgt0, tgt1, tgt2;
  logic [3:0]  idx0, idx1, idx2;
  logic [3:0]  ghr0, ghr1, ghr2;
  logic [31:0] sb0, sm0, sb1, sm1, sb2, sm2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(0)) dut0 (
    .clk(clk), .reset(reset), .lookup_pc(pc), .lookup_instruction(inst),
    .predict_is_branch(isBr0), .predict_taken(tk0), .predict_target(tgt0),
    .predict_index(idx0), .update_valid(upValid), .update_index(upIdx),
    .update_taken(upTaken), .update_mispredict(upMisp), .ghr_out(ghr0),
    .stat_branches(sb0), .stat_mispredicts(sm0));

  branch_predictor #(.MODE(1)) dut1 (
    .clk(clk), .reset(reset), .lookup_pc(pc), .lookup_instruction(inst),
    .predict_is_branch(isBr1), .predict_taken(tk1), .predict_target(tgt1),
    .predict_index(idx1), .update_valid(upValid), .update_index(upIdx),
    .update_taken(upTaken), .update_mispredict(upMisp), .ghr_out(ghr1),
    .stat_branches(sb1), .stat_mispredicts(sm1));

  branch_predictor #(.MODE(2)) dut2 (
    .clk(clk), .reset(reset), .lookup_pc(pc), .lookup_instruction(inst),
    .predict_is_branch(isBr2), .predict_taken(tk2), .predict_target(tgt2),
    .predict_index(idx2), .update_valid(up2Valid), .update_index(upIdx),
    .update_taken(upTaken), .update_mispredict(upMisp), .ghr_out(ghr2),
    .stat_branches(sb2), .stat_mispredicts(sm2));

  task automatic clockCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One resolved-branch update, committed on the next rising edge.
  task automatic applyStimulus(input logic v1, input logic v2, input logic [3:0] idx,
                               input logic taken, input logic misp);
    upValid  = v1;
    up2Valid = v2;
    upIdx    = idx;
    upTaken  = taken;
    upMisp   = misp;
    clockCycle();
    upValid  = 1'b0;
    up2Valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; upValid = 1'b0; up2Valid = 1'b0; upIdx = 4'd0;
    upTaken = 1'b0; upMisp = 1'b0; pc = 64'h10; inst = 32'h0000_0463;
    clockCycle();
    clockCycle();
    reset = 1'b0;
    #1;

    $display("[TB] reset state and first lookup");
    checkOutput("t1_isbranch", 64'(isBr1), 64'h1);
    checkOutput("t1_taken", 64'(tk1), 64'h1);
    checkOutput("t1_target", tgt1, 64'h18);
    checkOutput("t1_index", 64'(idx1), 64'h4);
    checkOutput("t1_stat_br", 64'(sb1), 64'h0);
    checkOutput("t1_stat_mp", 64'(sm1), 64'h0);
    checkOutput("t1_ghr", 64'(ghr1), 64'h0);
    checkOutput("t1_gshare_index", 64'(idx2), 64'h4);
    checkOutput("t1_static_taken", 64'(tk0), 64'h1);

    $display("[TB] bimodal training down and back up");
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    checkOutput("t2_taken_nt3", 64'(tk1), 64'h0);
    checkOutput("t2_target_nt3", tgt1, 64'h14);
    checkOutput("t2_stat_br", 64'(sb1), 64'h3);
    checkOutput("t2_stat_mp", 64'(sm1), 64'h1);
    checkOutput("t2_static_taken", 64'(tk0), 64'h1);
    checkOutput("t2_static_target", tgt0, 64'h18);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b1);
    checkOutput("t2_taken_t1", 64'(tk1), 64'h0);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b1);
    checkOutput("t2_taken_t2", 64'(tk1), 64'h1);
    checkOutput("t2_stat_mp_end", 64'(sm1), 64'h3);
    checkOutput("t2_ghr", 64'(ghr1), 64'h3);

    $display("[TB] upper saturation");
    reset = 1'b1;
    clockCycle();
    reset = 1'b0;
    #1;
    checkOutput("t3_stat_br_reset", 64'(sb1), 64'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    checkOutput("t3_taken_t5", 64'(tk1), 64'h1);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    checkOutput("t3_taken_t6", 64'(tk1), 64'h1);
    applyStimulus(1'b1, 1'b0, 4'd4, 1'b0, 1'b1);
    checkOutput("t3_taken_after_nt", 64'(tk1), 64'h1);
    checkOutput("t3_stat_br", 64'(sb1), 64'h7);
    checkOutput("t3_stat_mp", 64'(sm1), 64'h1);
    checkOutput("t3_ghr", 64'(ghr1), 64'he);

    $display("[TB] gshare history and index");
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    checkOutput("t4_gshare_ghr", 64'(ghr2), 64'h6);
    checkOutput("t4_gshare_stat_br", 64'(sb2), 64'h3);
    checkOutput("t4_bimodal_ghr_hold", 64'(ghr1), 64'he);
    checkOutput("t4_bimodal_stat_hold", 64'(sb1), 64'h7);
    pc = 64'h40;
    #1;
    checkOutput("t4_gshare_index_40", 64'(idx2), 64'h6);
    checkOutput("t4_bimodal_index_40", 64'(idx1), 64'h0);
    pc = 64'h10;
    #1;
    checkOutput("t4_gshare_index_10", 64'(idx2), 64'h2);

    $display("[TB] same-cycle lookup and update");
    upValid = 1'b1; upIdx = 4'd4; upTaken = 1'b0; upMisp = 1'b0;
    #1;
    checkOutput("t5_taken_same_cycle", 64'(tk1), 64'h1);
    clockCycle();
    upValid = 1'b0;
    #1;
    checkOutput("t5_taken_next_cycle", 64'(tk1), 64'h0);

    $display("[TB] negative offset, non-branch and reset priority");
    pc = 64'h0; inst = 32'hFE00_0EE3;
    #1;
    checkOutput("t6_taken_back", 64'(tk1), 64'h1);
    checkOutput("t6_target_wrap", tgt1, 64'hFFFF_FFFF_FFFF_FFFC);
    pc = 64'h10; inst = 32'h0000_0013;
    #1;
    checkOutput("t6_nop_isbranch", 64'(isBr1), 64'h0);
    checkOutput("t6_nop_taken", 64'(tk1), 64'h0);
    checkOutput("t6_nop_target", tgt1, 64'h14);
    checkOutput("t6_nop_static_taken", 64'(tk0), 64'h0);
    inst = 32'h0000_0463;
    reset = 1'b1; upValid = 1'b1; up2Valid = 1'b1; upIdx = 4'd4;
    upTaken = 1'b0; upMisp = 1'b1;
    clockCycle();
    reset = 1'b0; upValid = 1'b0; up2Valid = 1'b0;
    #1;
    checkOutput("t6_reset_stat_br", 64'(sb1), 64'h0);
    checkOutput("t6_reset_stat_mp", 64'(sm1), 64'h0);
    checkOutput("t6_reset_ghr", 64'(ghr1), 64'h0);
    checkOutput("t6_reset_gshare_ghr", 64'(ghr2), 64'h0);
    checkOutput("t6_reset_ctr_taken", 64'(tk1), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
